// File: rtl/win_logic_pkg.sv
// Shared encodings and line table for the tic-tac-toe win/draw detector.
package win_logic_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10,
    BAD   = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    W_NONE     = 2'b00,
    W_X        = 2'b01,
    W_O        = 2'b10,
    W_CONFLICT = 2'b11
  } winner_t;

  localparam int NUM_CELLS  = 9;
  localparam int NUM_LINES  = 8;
  localparam int BOARD_BITS = 2 * NUM_CELLS;

  // Cell indices of every winning line: three rows, three columns, two diagonals.
  localparam int LINES [NUM_LINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

endpackage

// File: rtl/win_logic_line_check.sv
// Flags whether one three-cell line is owned entirely by X or entirely by O.
module win_line_check
  import win_logic_pkg::*;
(
  input  logic [1:0] cell_a,
  input  logic [1:0] cell_b,
  input  logic [1:0] cell_c,
  output logic       x_line,
  output logic       o_line
);

  assign x_line = (cell_a == X) && (cell_b == X) && (cell_c == X);
  assign o_line = (cell_a == O) && (cell_b == O) && (cell_c == O);

endmodule

// File: rtl/win_logic.sv
// Tic-tac-toe win/draw detector: combinational decode of the board, registered result.
module win_logic
  import win_logic_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [BOARD_BITS-1:0] gBoard,
  output logic                  gameIsDone,
  output logic [1:0]            winner
);

  logic [NUM_LINES-1:0] x_hits;
  logic [NUM_LINES-1:0] o_hits;
  logic                 x_win;
  logic                 o_win;
  logic                 full;
  logic                 done_next;
  winner_t              winner_next;
  logic                 done_q;
  winner_t              winner_q;

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    win_line_check u_line (
      .cell_a (gBoard[2*LINES[l][0] +: 2]),
      .cell_b (gBoard[2*LINES[l][1] +: 2]),
      .cell_c (gBoard[2*LINES[l][2] +: 2]),
      .x_line (x_hits[l]),
      .o_line (o_hits[l])
    );
  end

  assign x_win = |x_hits;
  assign o_win = |o_hits;

  // Illegal 11 cells count as empty, so they keep the board from being full.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    full = 1'b1;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (!((gBoard[2*i +: 2] == X) || (gBoard[2*i +: 2] == O))) begin
        full = 1'b0;
      end
    end
  end

  // A win always beats a draw; both players winning is an impossible board.
  always_comb begin
    done_next   = 1'b0;
    winner_next = W_NONE;
    unique case ({x_win, o_win})
      2'b11: begin done_next = 1'b1; winner_next = W_CONFLICT; end
      2'b10: begin done_next = 1'b1; winner_next = W_X;        end
      2'b01: begin done_next = 1'b1; winner_next = W_O;        end
      default: begin
        done_next   = full;
        winner_next = W_NONE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and a full async reset to a known value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q   <= 1'b0;
      winner_q <= W_NONE;
    end else begin
      done_q   <= done_next;
      winner_q <= winner_next;
    end
  end

  assign gameIsDone = done_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_win_logic.sv
// Self-checking bench for win_logic: directed vectors, line sweep, random boards vs a grid model.
module tb_win_logic;

  logic        clk;
  logic        reset_n;
  logic [17:0] gBoard;
  logic        gameIsDone;
  logic [1:0]  winner;

  int tests_run    = 0;
  int tests_failed = 0;

  win_logic dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .gBoard     (gBoard),
    .gameIsDone (gameIsDone),
    .winner     (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: view the board as a 3x3 grid and scan rows, columns and diagonals.
  function automatic logic [2:0] ref_result(input logic [17:0] b);
    int   g [3][3];
    int   filled;
    logic win [3];
    logic [1:0] v;
    filled = 0;
    win[0] = 1'b0; win[1] = 1'b0; win[2] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        v = b[2*(r*3+c) +: 2];
        g[r][c] = (v == 2'b01) ? 1 : (v == 2'b10) ? 2 : 0;
        if (g[r][c] != 0) filled++;
      end
    end
    for (int p = 1; p <= 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        if (g[i][0] == p && g[i][1] == p && g[i][2] == p) win[p] = 1'b1;
        if (g[0][i] == p && g[1][i] == p && g[2][i] == p) win[p] = 1'b1;
      end
      if (g[0][0] == p && g[1][1] == p && g[2][2] == p) win[p] = 1'b1;
      if (g[0][2] == p && g[1][1] == p && g[2][0] == p) win[p] = 1'b1;
    end
    if (win[1] && win[2]) return 3'b1_11;
    if (win[1])           return 3'b1_01;
    if (win[2])           return 3'b1_10;
    if (filled == 9)      return 3'b1_00;
    return 3'b0_00;
  endfunction

  function automatic logic [17:0] rand_board();
    logic [17:0] b;
    int          r;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      r = $urandom_range(0, 15);
      b[2*i +: 2] = (r < 6) ? 2'b01 : (r < 12) ? 2'b10 : (r < 15) ? 2'b00 : 2'b11;
    end
    return b;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    gBoard  = 18'h00015;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({gameIsDone, winner} !== 3'b0_00) begin
      tests_failed++;
      $display("FAIL reset_hold: got done=%b winner=%b, want done=0 winner=00", gameIsDone, winner);
    end
    @(negedge clk);
    gBoard  = 18'h00000;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({gameIsDone, winner} !== 3'b0_00) begin
      tests_failed++;
      $display("FAIL reset_first_empty: got done=%b winner=%b, want done=0 winner=00", gameIsDone, winner);
    end
  endtask

  task automatic test_directed();
    logic [17:0] boards [9];
    logic [2:0]  want   [9];
    boards[0] = 18'h00000;               want[0] = 3'b0_00;
    boards[1] = 18'h00015;               want[1] = 3'b1_01;
    boards[2] = 18'h00005;               want[2] = 3'b0_00;
    boards[3] = 18'h20202;               want[3] = 3'b1_10;
    boards[4] = 18'h02220;               want[4] = 3'b1_10;
    boards[5] = 18'b010110101001011001;  want[5] = 3'b1_00;
    boards[6] = 18'b110110101001011001;  want[6] = 3'b0_00;
    boards[7] = 18'h00A95;               want[7] = 3'b1_11;
    boards[8] = 18'b100101101001011001;  want[8] = 3'b1_01;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      gBoard = boards[i];
      @(posedge clk);
      #1;
      tests_run++;
      if ({gameIsDone, winner} !== want[i]) begin
        tests_failed++;
        $display("FAIL directed[%0d] board=%05h: got done=%b winner=%b, want done=%b winner=%b",
                 i, boards[i], gameIsDone, winner, want[i][2], want[i][1:0]);
      end
    end
  endtask

  task automatic test_line_sweep();
    int          cells [8][3];
    logic [17:0] b;
    cells = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    for (int p = 1; p <= 2; p++) begin
      for (int l = 0; l < 8; l++) begin
        b = '0;
        for (int k = 0; k < 3; k++) b[2*cells[l][k] +: 2] = 2'(p);
        @(negedge clk);
        gBoard = b;
        @(posedge clk);
        #1;
        tests_run++;
        if (gameIsDone !== 1'b1 || winner !== 2'(p)) begin
          tests_failed++;
          $display("FAIL sweep player=%0d line=%0d: got done=%b winner=%b, want done=1 winner=%0d",
                   p, l, gameIsDone, winner, p);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [17:0] b;
    logic [2:0]  exp;
    for (int i = 0; i < 300; i++) begin
      b = rand_board();
      exp = ref_result(b);
      @(negedge clk);
      gBoard = b;
      @(posedge clk);
      #1;
      tests_run++;
      if ({gameIsDone, winner} !== exp) begin
        tests_failed++;
        $display("FAIL random[%0d] board=%05h: got done=%b winner=%b, want done=%b winner=%b",
                 i, b, gameIsDone, winner, exp[2], exp[1:0]);
      end
    end
  endtask

  // Board changes right after each edge; outputs must still show the previous board until the next edge.
  task automatic test_back_to_back();
    logic [17:0] b;
    logic [2:0]  prev_exp;
    logic [2:0]  exp;
    @(negedge clk);
    gBoard = 18'h00015;
    @(posedge clk);
    #1;
    prev_exp = 3'b1_01;
    for (int i = 0; i < 40; i++) begin
      b = (i % 4 == 0) ? 18'h00000 : rand_board();
      exp = ref_result(b);
      gBoard = b;
      #1;
      tests_run++;
      if ({gameIsDone, winner} !== prev_exp) begin
        tests_failed++;
        $display("FAIL b2b_hold[%0d]: got done=%b winner=%b, want done=%b winner=%b",
                 i, gameIsDone, winner, prev_exp[2], prev_exp[1:0]);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({gameIsDone, winner} !== exp) begin
        tests_failed++;
        $display("FAIL b2b_update[%0d] board=%05h: got done=%b winner=%b, want done=%b winner=%b",
                 i, b, gameIsDone, winner, exp[2], exp[1:0]);
      end
      prev_exp = exp;
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    gBoard = 18'h00015;
    @(posedge clk);
    #1;
    tests_run++;
    if ({gameIsDone, winner} !== 3'b1_01) begin
      tests_failed++;
      $display("FAIL midreset_pre: got done=%b winner=%b, want done=1 winner=01", gameIsDone, winner);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({gameIsDone, winner} !== 3'b0_00) begin
      tests_failed++;
      $display("FAIL midreset_async: got done=%b winner=%b, want done=0 winner=00", gameIsDone, winner);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({gameIsDone, winner} !== 3'b0_00) begin
      tests_failed++;
      $display("FAIL midreset_hold: got done=%b winner=%b, want done=0 winner=00", gameIsDone, winner);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests_run++;
    if ({gameIsDone, winner} !== 3'b0_00) begin
      tests_failed++;
      $display("FAIL midreset_release: got done=%b winner=%b, want done=0 winner=00", gameIsDone, winner);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({gameIsDone, winner} !== 3'b1_01) begin
      tests_failed++;
      $display("FAIL midreset_first_edge: got done=%b winner=%b, want done=1 winner=01", gameIsDone, winner);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    gBoard  = '0;
    test_reset();
    test_directed();
    test_line_sweep();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
